adder_slice_sequencer: RTL

ADDER_SLICE_SEQUENCER -- requirements
Module: adder_slice_sequencer

---
 rtl/adder_seq_pkg.sv | 20 ++
 rtl/adder_slice.sv | 28 ++
 rtl/adder_slice_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types and sizing for the slice-serial adder sequencer.
package adder_seq_pkg;

   localparam int WIDTH_DEF   = 32;
   localparam int SLICE_W_DEF = 8;

   // Number of slice steps needed to cover a full operand
   function automatic int calc_nslice(input int width, input int slice_w);
      return width / slice_w;
   endfunction

   localparam int NSLICE_DEF = calc_nslice(WIDTH_DEF, SLICE_W_DEF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/adder_slice.sv
// Combinational ripple-carry adder for one slice of the operands.
module adder_slice
   import adder_seq_pkg::*;
#(
   parameter int SLICE_W = SLICE_W_DEF
) (
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               ci,
   output logic [SLICE_W-1:0] s,
   output logic               co
);

   logic [SLICE_W:0] c;

   // Ripple the carry bit by bit from the LSB of the slice
   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = ci;
      for (int i = 0; i < SLICE_W; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      co = c[SLICE_W];
   end

endmodule

// File: rtl/adder_slice_sequencer.sv
// Two-requester adder that computes one slice per cycle through a shared
// slice adder, with round-robin arbitration and a held response.
module adder_slice_sequencer
   import adder_seq_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int SLICE_W = SLICE_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [2*WIDTH-1:0] req_x,
   input  logic [2*WIDTH-1:0] req_y,
   input  logic [1:0]         req_ci,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [WIDTH-1:0]   rsp_sum,
   output logic               rsp_co,
   output logic               rsp_id,
   output logic               busy
);

   localparam int NSLICE = calc_nslice(WIDTH, SLICE_W);
   localparam int K_W    = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [K_W-1:0] K_LAST = K_W'(NSLICE - 1);

   state_t             state;
   state_t             next_state;
   logic [WIDTH-1:0]   x_q;
   logic [WIDTH-1:0]   y_q;
   logic [WIDTH-1:0]   sum_q;
   logic               carry;
   logic               id_q;
   logic               prio;
   logic               grant;
   logic               accept;
   logic [K_W-1:0]     k;
   logic [SLICE_W-1:0] slice_a;
   logic [SLICE_W-1:0] slice_b;
   logic [SLICE_W-1:0] slice_s;
   logic               slice_co;

   assign slice_a = x_q[int'(k)*SLICE_W +: SLICE_W];
   assign slice_b = y_q[int'(k)*SLICE_W +: SLICE_W];

   adder_slice #(
      .SLICE_W (SLICE_W)
   ) u_slice (
      .a  (slice_a),
      .b  (slice_b),
      .ci (carry),
      .s  (slice_s),
      .co (slice_co)
   );

   // Arbitration, handshake and next-state selection
   always_comb begin
      next_state = state;
      req_ready  = 2'b00;
      grant      = prio;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            grant            = req_valid[prio] ? prio : ~prio;
            req_ready[grant] = req_valid[grant];
            accept           = req_valid[grant];
            if (accept) next_state = ADD;
         end
         ADD: begin
            if (k == K_LAST) next_state = DONE;
         end
         DONE: begin
            if (rsp_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Operand capture, slice-serial accumulation and priority tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q   <= '0;
         y_q   <= '0;
         sum_q <= '0;
         carry <= 1'b0;
         id_q  <= 1'b0;
         prio  <= 1'b0;
         k     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  x_q   <= req_x[int'(grant)*WIDTH +: WIDTH];
                  y_q   <= req_y[int'(grant)*WIDTH +: WIDTH];
                  carry <= req_ci[grant];
                  id_q  <= grant;
                  k     <= '0;
               end
            end
            ADD: begin
               sum_q[int'(k)*SLICE_W +: SLICE_W] <= slice_s;
               carry <= slice_co;
               if (k == K_LAST) k <= '0;
               else             k <= k + 1'b1;
            end
            DONE: begin
               if (rsp_ready) prio <= ~id_q;
            end
            default: ;
         endcase
      end
   end

   assign rsp_valid = (state == DONE);
   assign rsp_sum   = sum_q;
   assign rsp_co    = carry;
   assign rsp_id    = id_q;
   assign busy      = (state != IDLE);

endmodule
